sddr_rd_capture: RTL



---
 rtl/sddr_pkg.sv | 31 +++
 rtl/sddr_rd_latency_queue.sv | 72 +++++++
 rtl/sddr_rd_capture.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/sddr_pkg.sv
// Shared definitions for the simple DDR controller: capture FSM states,
// burst geometry helper and DDR3 command encodings.
package sddr_pkg;

    // Read-capture FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } cap_state_t;

    // DDR3 command encodings as {RAS#, CAS#, WE#}
    typedef enum logic [2:0] {
        CMD_MRS   = 3'b000,
        CMD_REF   = 3'b001,
        CMD_PRE   = 3'b010,
        CMD_ACT   = 3'b011,
        CMD_WRITE = 3'b100,
        CMD_READ  = 3'b101,
        CMD_NOP   = 3'b111
    } ddr_cmd_t;

    localparam int unsigned DEFAULT_BURST_LENGTH = 8;
    localparam int unsigned HALF_BURST_LENGTH    = DEFAULT_BURST_LENGTH / 2;

    // Number of DQ beat pairs (clock cycles) in a burst
    function automatic int unsigned half_burst(input int unsigned burst_length);
        return burst_length / 2;
    endfunction

endpackage

// File: rtl/sddr_rd_latency_queue.sv
// In-order queue of outstanding READ commands. Each entry counts down the
// remaining CAS latency; head_zero flags that the oldest read's data is due.
module sddr_rd_latency_queue
    import sddr_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned LAT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [LAT_BITS-1:0] latency,
    input  logic                pop,
    output logic                head_zero,
    output logic                full,
    output logic                empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [LAT_BITS-1:0] remain [DEPTH];
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [CNT_W-1:0]    count;
    logic [LAT_BITS-1:0] load;
    logic                push_ok;
    logic                pop_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign head_zero = !empty && (remain[head] == '0);
    assign pop_ok    = pop && !empty;
    // A full queue still accepts a push when the head leaves on the same edge
    assign push_ok   = push && (!full || pop_ok);
    assign load      = (latency == '0) ? '0 : latency - 1'b1;

    // Countdown, push/pop pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                remain[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (remain[i] != '0) begin
                    remain[i] <= remain[i] - 1'b1;
                end
            end
            if (push_ok) begin
                remain[tail] <= load;
                tail         <= next_ptr(tail);
            end
            if (pop_ok) begin
                head <= next_ptr(head);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sddr_rd_capture.sv
// Read-return datapath: waits CAS latency per issued READ, samples the DDR
// DQ beat pairs of the burst and presents the packed word with a one-cycle
// ready pulse. Optional completed-burst counter: define SDDR_RD_STATS_EN.
module sddr_rd_capture
    import sddr_pkg::*;
#(
    parameter int unsigned DATA_BITS       = 16,
    parameter int unsigned BURST_LENGTH    = 8,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned LAT_BITS        = 16
) (
    input  logic                              ddr_clock_i,
    input  logic                              ctrl_reset_i,
    input  logic                              read_issue_i,
    input  logic [LAT_BITS-1:0]               cas_read_latency_i,
    input  logic [1:0][DATA_BITS-1:0]         ddr3_dq_i,
    output logic                              data_rsp_ready_o,
    output logic [BURST_LENGTH*DATA_BITS-1:0] data_rsp_data_o,
    output logic                              busy_o,
    output logic                              overflow_err_o,
    output logic                              collision_err_o,
    output logic [31:0]                       rsp_count_o
);

    localparam int unsigned HALF  = half_burst(BURST_LENGTH);
    localparam int unsigned IDX_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(HALF - 1);

    cap_state_t                                state;
    logic [IDX_W-1:0]                          idx;
    logic [BURST_LENGTH-1:0][DATA_BITS-1:0]    accum;
    logic [BURST_LENGTH-1:0][DATA_BITS-1:0]    beats_next;
    logic [BURST_LENGTH-1:0][DATA_BITS-1:0]    rsp_data;
    logic                                      rsp_ready;
    logic                                      overflow_err;
    logic                                      collision_err;

    logic             head_zero;
    logic             full;
    logic             empty;
    logic             start;
    logic             collide;
    logic             pop;
    logic             sample;
    logic             last;
    logic [IDX_W-1:0] k;

    sddr_rd_latency_queue #(
        .DEPTH    (MAX_OUTSTANDING),
        .LAT_BITS (LAT_BITS)
    ) u_latency_queue (
        .clk       (ddr_clock_i),
        .rst       (ctrl_reset_i),
        .push      (read_issue_i),
        .latency   (cas_read_latency_i),
        .pop       (pop),
        .head_zero (head_zero),
        .full      (full),
        .empty     (empty)
    );

    // Decide whether a burst starts or collides this cycle and merge the current beat pair
    always_comb begin
        start   = 1'b0;
        collide = 1'b0;
        if (head_zero) begin
            if (state == IDLE || state == DONE) begin
                start = 1'b1;
            end else if (idx != LAST) begin
                collide = 1'b1;
            end
        end
        pop    = start || collide;
        sample = start || (state == CAPTURE);
        k      = start ? '0 : idx;
        last   = (k == LAST);
        beats_next = accum;
        beats_next[{k, 1'b0}] = ddr3_dq_i[0];
        beats_next[{k, 1'b1}] = ddr3_dq_i[1];
    end

    // Capture FSM with registered response and sticky error flags
    always_ff @(posedge ddr_clock_i) begin
        if (ctrl_reset_i) begin
            state         <= IDLE;
            idx           <= '0;
            accum         <= '0;
            rsp_data      <= '0;
            rsp_ready     <= 1'b0;
            overflow_err  <= 1'b0;
            collision_err <= 1'b0;
        end else begin
            rsp_ready <= 1'b0;
            if (sample) begin
                accum <= beats_next;
                if (last) begin
                    state     <= DONE;
                    idx       <= '0;
                    rsp_data  <= beats_next;
                    rsp_ready <= 1'b1;
                end else begin
                    state <= CAPTURE;
                    idx   <= k + 1'b1;
                end
            end else begin
                state <= IDLE;
            end
            if (collide) begin
                collision_err <= 1'b1;
            end
            if (read_issue_i && full && !pop) begin
                overflow_err <= 1'b1;
            end
        end
    end

    assign data_rsp_ready_o = rsp_ready;
    assign data_rsp_data_o  = rsp_data;
    assign overflow_err_o   = overflow_err;
    assign collision_err_o  = collision_err;
    assign busy_o           = !empty || (state != IDLE);

`ifdef SDDR_RD_STATS_EN
    logic [31:0] rsp_count;

    // Count delivered bursts, wrapping naturally at 2^32
    always_ff @(posedge ddr_clock_i) begin
        if (ctrl_reset_i) begin
            rsp_count <= '0;
        end else if (rsp_ready) begin
            rsp_count <= rsp_count + 1'b1;
        end
    end

    assign rsp_count_o = rsp_count;
`else
    assign rsp_count_o = '0;
`endif

endmodule
